// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch / execute-stage sequencer.
// Owns the PC, instruction register and status flags, and walks each
// instruction through FETCH -> EX0 -> EX1 [-> EX2], or parks in HALT
// when an all-zero opcode class is decoded.
module fetch_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] mem_data,
  input  logic        mem_ready,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic        status_load,
  input  logic [3:0]  status_in,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [15:0] IR,
  output logic [3:0]  status,
  output logic [1:0]  stage,
  output logic        instr_done,
  output logic        halted
);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EX0   = 3'd1,
    ST_EX1   = 3'd2,
    ST_EX2   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // Opcode classes that change the sequencing, taken from IR[13:11].
  localparam logic [2:0] CLASS_HALT = 3'b000;
  localparam logic [2:0] CLASS_MEM  = 3'b001;  // LDR/STR need a third execute cycle

  // Stage codes presented to the control-word selector.
  localparam logic [1:0] STAGE_EX0  = 2'd0;
  localparam logic [1:0] STAGE_EX1  = 2'd1;
  localparam logic [1:0] STAGE_EX2  = 2'd2;
  localparam logic [1:0] STAGE_NONE = 2'd3;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  status_q, status_d;

  logic [2:0]  op_class;
  logic        is_halt_class;
  logic        is_mem_class;

  assign op_class      = ir_q[13:11];
  assign is_halt_class = (op_class == CLASS_HALT);
  assign is_mem_class  = (op_class == CLASS_MEM);

  // Next-state and register-update logic; everything holds unless a state
  // explicitly allows the update.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    status_d = status_q;
    unique case (state_q)
      ST_FETCH: begin
        // Stall here for as long as memory keeps mem_ready low.
        if (mem_ready) begin
          ir_d    = mem_data;
          pc_d    = pc_q + 16'd1;  // natural 16-bit wrap FFFF -> 0000
          state_d = ST_EX0;
        end
      end
      ST_EX0: begin
        if (status_load) begin
          status_d = status_in;
        end
        state_d = is_halt_class ? ST_HALT : ST_EX1;
      end
      ST_EX1: begin
        if (status_load) begin
          status_d = status_in;
        end
        if (pc_load) begin
          pc_d = pc_load_value;
        end
        state_d = is_mem_class ? ST_EX2 : ST_FETCH;
      end
      ST_EX2: begin
        if (status_load) begin
          status_d = status_in;
        end
        if (pc_load) begin
          pc_d = pc_load_value;
        end
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        // Frozen until reset.
        state_d = ST_HALT;
      end
      default: begin
        // Unused encodings recover to a clean fetch.
        state_d = ST_FETCH;
      end
    endcase
  end

  // Output decode, purely from the state register (and IR class for instr_done).
  always_comb begin
    mem_rd     = 1'b0;
    stage      = STAGE_NONE;
    instr_done = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        mem_rd = 1'b1;
      end
      ST_EX0: begin
        stage = STAGE_EX0;
      end
      ST_EX1: begin
        stage      = STAGE_EX1;
        instr_done = !is_mem_class;
      end
      ST_EX2: begin
        stage      = STAGE_EX2;
        instr_done = 1'b1;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        stage = STAGE_NONE;
      end
    endcase
  end

  assign mem_addr = pc_q;
  assign IR       = ir_q;
  assign status   = status_q;

  // State and datapath registers; reset wins over every load request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= 16'h0000;
      ir_q     <= 16'h0000;
      status_q <= 4'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table plus hand-written corner sequences.
module tb_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic        status_load;
  logic [3:0]  status_in;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] IR;
  logic [3:0]  status;
  logic [1:0]  stage;
  logic        instr_done;
  logic        halted;

  int total;
  int bad;

  fetch_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .mem_data      (mem_data),
    .mem_ready     (mem_ready),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .status_load   (status_load),
    .status_in     (status_in),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .IR            (IR),
    .status        (status),
    .stage         (stage),
    .instr_done    (instr_done),
    .halted        (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [15:0] md;
    logic        mr;
    logic        pl;
    logic [15:0] plv;
    logic        sl;
    logic [3:0]  si;
    logic [15:0] e_addr;
    logic        e_rd;
    logic [15:0] e_ir;
    logic [3:0]  e_st;
    logic [1:0]  e_stage;
    logic        e_done;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst, input logic [15:0] md, input logic mr,
                         input logic pl, input logic [15:0] plv,
                         input logic sl, input logic [3:0] si,
                         input logic [15:0] e_addr, input logic e_rd,
                         input logic [15:0] e_ir, input logic [3:0] e_st,
                         input logic [1:0] e_stage, input logic e_done,
                         input logic e_halt);
    vec_t v;
    v.rst = rst; v.md = md; v.mr = mr; v.pl = pl; v.plv = plv; v.sl = sl; v.si = si;
    v.e_addr = e_addr; v.e_rd = e_rd; v.e_ir = e_ir; v.e_st = e_st;
    v.e_stage = e_stage; v.e_done = e_done; v.e_halt = e_halt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_addr, input logic e_rd,
                           input logic [15:0] e_ir, input logic [3:0] e_st,
                           input logic [1:0] e_stage, input logic e_done,
                           input logic e_halt);
    chk({tag, ".mem_addr"},   mem_addr,   e_addr);
    chk({tag, ".mem_rd"},     {15'd0, mem_rd},     {15'd0, e_rd});
    chk({tag, ".IR"},         IR,         e_ir);
    chk({tag, ".status"},     {12'd0, status},     {12'd0, e_st});
    chk({tag, ".stage"},      {14'd0, stage},      {14'd0, e_stage});
    chk({tag, ".instr_done"}, {15'd0, instr_done}, {15'd0, e_done});
    chk({tag, ".halted"},     {15'd0, halted},     {15'd0, e_halt});
    $display("%s: addr=%h rd=%0d IR=%h st=%h stage=%0d done=%0d halt=%0d",
             tag, mem_addr, mem_rd, IR, status, stage, instr_done, halted);
  endtask

  // Apply one cycle of inputs, let the edge happen, then settle before sampling.
  task automatic cyc(input logic rst, input logic [15:0] md, input logic mr,
                     input logic pl, input logic [15:0] plv,
                     input logic sl, input logic [3:0] si);
    reset = rst; mem_data = md; mem_ready = mr;
    pc_load = pl; pc_load_value = plv; status_load = sl; status_in = si;
    @(posedge clock);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1; mem_data = 16'h0; mem_ready = 1'b0;
    pc_load = 1'b0; pc_load_value = 16'h0; status_load = 1'b0; status_in = 4'h0;

    //      rst md      mr pl plv      sl si   | addr    rd IR       st   stg done halt
    add_vec(1, 16'h0000, 0, 0, 16'h0000, 0, 4'h0, 16'h0000, 1, 16'h0000, 4'h0, 3, 0, 0);
    add_vec(0, 16'h2400, 1, 0, 16'h0000, 0, 4'h0, 16'h0001, 0, 16'h2400, 4'h0, 0, 0, 0);
    add_vec(0, 16'hFFFF, 1, 0, 16'h0000, 0, 4'h0, 16'h0001, 0, 16'h2400, 4'h0, 1, 1, 0);
    add_vec(0, 16'hFFFF, 1, 0, 16'h0000, 0, 4'h0, 16'h0001, 1, 16'h2400, 4'h0, 3, 0, 0);
    add_vec(0, 16'h0800, 1, 0, 16'h0000, 0, 4'h0, 16'h0002, 0, 16'h0800, 4'h0, 0, 0, 0);
    add_vec(0, 16'h0000, 0, 0, 16'h0000, 1, 4'hA, 16'h0002, 0, 16'h0800, 4'hA, 1, 0, 0);
    add_vec(0, 16'h0000, 0, 0, 16'h0000, 1, 4'h3, 16'h0002, 0, 16'h0800, 4'h3, 2, 1, 0);
    add_vec(0, 16'h0000, 0, 1, 16'h0100, 1, 4'hC, 16'h0100, 1, 16'h0800, 4'hC, 3, 0, 0);
    add_vec(0, 16'h3812, 1, 1, 16'h0055, 1, 4'h5, 16'h0101, 0, 16'h3812, 4'hC, 0, 0, 0);
    add_vec(0, 16'h0000, 0, 1, 16'h0012, 0, 4'h0, 16'h0101, 0, 16'h3812, 4'hC, 1, 1, 0);
    add_vec(0, 16'h0000, 0, 1, 16'h0012, 0, 4'h0, 16'h0012, 1, 16'h3812, 4'hC, 3, 0, 0);
    add_vec(0, 16'h3812, 1, 0, 16'h0000, 0, 4'h0, 16'h0013, 0, 16'h3812, 4'hC, 0, 0, 0);
    add_vec(0, 16'h0000, 0, 1, 16'h0040, 0, 4'h0, 16'h0013, 0, 16'h3812, 4'hC, 1, 1, 0);
    add_vec(0, 16'h0000, 0, 0, 16'h0000, 0, 4'h0, 16'h0013, 1, 16'h3812, 4'hC, 3, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].md, vecs[i].mr, vecs[i].pl, vecs[i].plv,
          vecs[i].sl, vecs[i].si);
      check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_rd, vecs[i].e_ir,
                vecs[i].e_st, vecs[i].e_stage, vecs[i].e_done, vecs[i].e_halt);
    end

    // Memory stall: nothing moves while mem_ready stays low.
    cyc(1, 16'h0000, 0, 0, 16'h0000, 0, 4'h0);
    check_all("stall_rst", 16'h0000, 1, 16'h0000, 4'h0, 3, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 16'h1234, 0, 0, 16'h0000, 0, 4'h0);
      check_all($sformatf("stall%0d", i), 16'h0000, 1, 16'h0000, 4'h0, 3, 0, 0);
    end

    // PC wrap: branch to FFFF, then the fetch there increments to 0000.
    cyc(0, 16'h2400, 1, 0, 16'h0000, 0, 4'h0);
    check_all("wrap_ex0", 16'h0001, 0, 16'h2400, 4'h0, 0, 0, 0);
    cyc(0, 16'h0000, 0, 0, 16'h0000, 0, 4'h0);
    check_all("wrap_ex1", 16'h0001, 0, 16'h2400, 4'h0, 1, 1, 0);
    cyc(0, 16'h0000, 0, 1, 16'hFFFF, 0, 4'h0);
    check_all("wrap_fetch", 16'hFFFF, 1, 16'h2400, 4'h0, 3, 0, 0);
    cyc(0, 16'h2400, 1, 0, 16'h0000, 0, 4'h0);
    check_all("wrap_after", 16'h0000, 0, 16'h2400, 4'h0, 0, 0, 0);

    // HALT: entered after EX0 of an all-zero word, frozen until reset.
    cyc(1, 16'h0000, 0, 0, 16'h0000, 0, 4'h0);
    check_all("halt_rst", 16'h0000, 1, 16'h0000, 4'h0, 3, 0, 0);
    cyc(0, 16'h0000, 1, 0, 16'h0000, 0, 4'h0);
    check_all("halt_ex0", 16'h0001, 0, 16'h0000, 4'h0, 0, 0, 0);
    cyc(0, 16'h0000, 0, 0, 16'h0000, 1, 4'h6);
    check_all("halt_enter", 16'h0001, 0, 16'h0000, 4'h6, 3, 0, 1);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 16'h2400, i[0], ~i[0], 16'h00AA, 1, 4'hF);
      check_all($sformatf("halt_hold%0d", i), 16'h0001, 0, 16'h0000, 4'h6, 3, 0, 1);
    end
    cyc(1, 16'h0000, 1, 1, 16'h00AA, 1, 4'hF);
    check_all("halt_exit", 16'h0000, 1, 16'h0000, 4'h0, 3, 0, 0);
    cyc(0, 16'h0000, 0, 0, 16'h0000, 0, 4'h0);
    check_all("halt_release", 16'h0000, 1, 16'h0000, 4'h0, 3, 0, 0);

    // Reset in EX1 beats simultaneous pc_load and status_load.
    cyc(0, 16'h2400, 1, 0, 16'h0000, 0, 4'h0);
    check_all("midrst_ex0", 16'h0001, 0, 16'h2400, 4'h0, 0, 0, 0);
    cyc(0, 16'h0000, 0, 0, 16'h0000, 1, 4'h9);
    check_all("midrst_ex1", 16'h0001, 0, 16'h2400, 4'h9, 1, 1, 0);
    cyc(1, 16'h0000, 0, 1, 16'h0077, 1, 4'hF);
    check_all("midrst_after", 16'h0000, 1, 16'h0000, 4'h0, 3, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
